lcd_bus_seq: RTL
================

LCD_BUS_SEQ -- requirements
Module: lcd_bus_seq

Interface
REQ-001 SHALL: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL: reset_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: address  input  2  Avalon-MM register select.
REQ-004 SHALL: chipselect  input  1  Avalon-MM slave select.
REQ-005 SHALL: write_n  input  1  active-low write strobe.
REQ-006 SHALL: read_n  input  1  active-low read strobe.
REQ-007 SHALL: writedata  input  16  write data.
REQ-008 SHALL: readdata  output  16  read data; zero-wait, combinational from address.
REQ-009 SHALL: lcd_cs_n  output  1  LCD chip select, active-low.
REQ-010 SHALL: lcd_rs  output  1  register select; 0 = command, 1 = data.
REQ-011 SHALL: lcd_wr_n  output  1  LCD write strobe, active-low.
REQ-012 SHALL: lcd_data  output  8  LCD data bus.

Function
REQ-013 SHALL decode writes (chipselect & ~write_n) as follows.
- addr0: push {rs=0, writedata[7:0]}.
- addr1: push {rs=1, writedata[7:0]}.
- addr2: load TIMING = writedata[11:0] as {hold[11:8], pulse[7:4], setup[3:0]}.
- addr3: clear the sticky overflow flag.
REQ-014 SHALL return on read of addr3: {11'b0, count[2:0], ovf, busy}, with busy = (state != IDLE) | ~empty. Read of addr2 returns {4'b0, TIMING}; reads of addr0 and addr1 return 0.
REQ-015 SHALL buffer pushes in a 4-entry, 9-bit FIFO.
- Push when full is dropped and sets ovf.
- Full is evaluated before any same-cycle pop, so a push to a full FIFO is dropped even when a pop occurs that cycle.
REQ-016 SHALL implement FSM states IDLE, SETUP, PULSE, HOLD.
REQ-017 IDLE: if FIFO not empty, SHALL pop, latch rs/data and the current TIMING into working registers, load counter = setup, and go to SETUP; otherwise remain in IDLE.
REQ-018 SETUP: SHALL hold cs_n=0, wr_n=1 and decrement the counter; at 0, load counter = pulse and go to PULSE.
REQ-019 PULSE: SHALL hold cs_n=0, wr_n=0; at 0, load counter = hold and go to HOLD.
REQ-020 HOLD: SHALL hold cs_n=0, wr_n=1; at 0, go to IDLE.
REQ-021 Each phase SHALL last field+1 clock cycles; a field value of 0 gives 1 cycle.
REQ-022 lcd_cs_n SHALL be high in IDLE, giving a minimum 1-cycle deselect between transfers.
REQ-023 lcd_rs and lcd_data SHALL be stable from SETUP entry through HOLD exit.
REQ-024 All LCD outputs SHALL be registered (no combinational glitches).
REQ-025 A TIMING write during a transfer SHALL affect only the next transfer.
REQ-026 Latency: a push accepted at edge t with the FSM in IDLE and the FIFO empty SHALL drive lcd_cs_n low after edge t+2.
REQ-027 Total transfer length SHALL be setup+pulse+hold+3 cycles plus 1 IDLE cycle.

Reset
REQ-028 On reset_n low, all of the following SHALL take effect immediately and asynchronously.
- state = IDLE; FIFO empty (count = 0); ovf = 0; TIMING = 12'h313.
- lcd_cs_n = 1, lcd_wr_n = 1, lcd_rs = 0, lcd_data = 8'h00.
REQ-029 Reset mid-transfer SHALL abort the transfer and discard all FIFO contents.

Structure
REQ-030 A shared package lcd_pkg SHALL hold the state enum, register address constants, FIFO depth (4) and the TIMING reset value.
REQ-031 The FIFO SHALL be a sub-module named lcd_cmd_fifo (parameterised width and depth, with count, full and empty outputs).
REQ-032 The FSM and phase counter SHALL reside in lcd_bus_seq.

Verification
REQ-033 Reset, then read addr3 -> 16'h0000; read addr2 -> 16'h0313; lcd_cs_n=1, lcd_wr_n=1.
REQ-034 Write addr1=0x41 with default TIMING -> lcd_cs_n low 2 cycles after write, with rs=1, data=0x41.
- setup low-phase: 4 cycles; wr_n low: 2 cycles; hold: 4 cycles.
- lcd_cs_n returns high after 10 cycles.
REQ-035 Write addr2=0x000, then addr0=0x38 -> 3-cycle transfer: cs_n low 3 cycles, wr_n low exactly 1 cycle (the middle one), rs=0.
REQ-036 Six back-to-back pushes 0x01..0x06 during an active transfer:
- first accepted, 4 queued, sixth dropped;
- ovf=1 on status read;
- exactly 5 transfers in order, each separated by 1 cycle of cs_n high;
- write addr3 -> ovf=0.
REQ-037 Write TIMING=0x555 mid-transfer -> current transfer keeps old timing; next transfer uses 6/6/6 cycles.
REQ-038 Assert reset_n during PULSE with 2 entries queued -> outputs return to reset values immediately; after release, no transfer occurs and status = 0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD bus sequencer.
// FSM states, register map, FIFO depth and reset values.
package lcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD
  } lcd_state_t;

  localparam logic [1:0] ADDR_CMD  = 2'd0;
  localparam logic [1:0] ADDR_DAT  = 2'd1;
  localparam logic [1:0] ADDR_TIM  = 2'd2;
  localparam logic [1:0] ADDR_STAT = 2'd3;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [11:0] TIMING_RST = 12'h313;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_entry_t;

  typedef struct packed {
    logic [3:0] hold;
    logic [3:0] pulse;
    logic [3:0] setup;
  } lcd_timing_t;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small command FIFO between the register port and the bus FSM.
// Pushes when full and pops when empty are ignored.
module lcd_cmd_fifo #(
  parameter  int W  = 9,
  parameter  int D  = 4,
  localparam int AW = (D > 1) ? $clog2(D) : 1,
  localparam int CW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign full    = (count == CW'(D));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rp];

  function automatic logic [AW-1:0] inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(D - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage array, written on accepted pushes.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= inc(wp);
      if (do_pop)  rp <= inc(rp);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_bus_seq.sv
// Avalon-MM slave that sequences queued bytes onto an 8080-style
// LCD bus with programmable setup/pulse/hold phases.
module lcd_bus_seq
  import lcd_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        lcd_cs_n,
  output logic        lcd_rs,
  output logic        lcd_wr_n,
  output logic [7:0]  lcd_data
);

  lcd_state_t       state, state_n;
  lcd_timing_t      timing, tm_w;
  logic [3:0]       cnt, cnt_n;
  logic             ovf;
  logic             wr, wr_fifo, wr_tim, wr_clr;
  logic             pop, full, empty, busy;
  logic [CNT_W-1:0] count;
  lcd_entry_t       wentry, rentry;
  logic             unused_in;

  assign wr      = chipselect & ~write_n;
  assign wr_fifo = wr & ~address[1];
  assign wr_tim  = wr & (address == ADDR_TIM);
  assign wr_clr  = wr & (address == ADDR_STAT);
  assign wentry  = {address == ADDR_DAT, writedata[7:0]};
  assign pop     = (state == IDLE) & ~empty;
  assign busy    = (state != IDLE) | ~empty;

  assign unused_in = ^{read_n, writedata[15:12]};

  lcd_cmd_fifo #(
    .W ($bits(lcd_entry_t)),
    .D (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (wr_fifo),
    .wdata   (wentry),
    .pop     (pop),
    .rdata   (rentry),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Zero-wait register readback.
  always_comb begin
    readdata = '0;
    unique case (address)
      ADDR_TIM:  readdata = {4'b0, timing};
      ADDR_STAT: readdata = {11'b0, count, ovf, busy};
      default:   readdata = '0;
    endcase
  end

  // Sticky overflow and the TIMING register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf    <= 1'b0;
      timing <= TIMING_RST;
    end else begin
      if (wr_fifo & full) ovf <= 1'b1;
      else if (wr_clr)    ovf <= 1'b0;
      if (wr_tim) timing <= writedata[11:0];
    end
  end

  // FSM state and phase counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state: each phase lasts field+1 cycles.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_n = SETUP;
          cnt_n   = timing.setup;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_n = PULSE;
          cnt_n   = tm_w.pulse;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_n = HOLD;
          cnt_n   = tm_w.hold;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered bus pins; rs/data/timing latched once per transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lcd_cs_n <= 1'b1;
      lcd_wr_n <= 1'b1;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
      tm_w     <= TIMING_RST;
    end else begin
      lcd_cs_n <= (state == IDLE);
      lcd_wr_n <= (state != PULSE);
      if (pop) begin
        lcd_rs   <= rentry.rs;
        lcd_data <= rentry.data;
        tm_w     <= timing;
      end
    end
  end

endmodule
